// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and helpers for the serial adder
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Digit counter width: clog2(width/digit), never less than one bit.
  function automatic int cnt_width(input int width, input int digit);
    int n;
    int w;
    n = width / digit;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/serial_adder_adder_slice.sv
// rtl/serial_adder_adder_slice.sv - combinational ripple adder of DIGIT full-adder bits
module adder_slice #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  // Ripple the carry through each bit; c_msb keeps the carry entering the top bit.
  always_comb begin
    logic c;
    c     = ci;
    s     = '0;
    c_msb = ci;
    for (int i = 0; i < DIGIT; i++) begin
      c_msb = c;
      s[i]  = x[i] ^ y[i] ^ c;
      c     = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    co = c;
  end

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - multi-cycle digit-serial adder/subtractor with valid/ready handshake
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(WIDTH, DIGIT);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $fatal(1, "serial_adder: WIDTH must be a multiple of DIGIT");
  end

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             cout_r;
  logic             ovf_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;

  logic [DIGIT-1:0] slice_s;
  logic             slice_co;
  logic             slice_c_msb;
  logic [WIDTH-1:0] res_next;

  adder_slice #(.DIGIT(DIGIT)) u_slice (
    .x     (a_sh[DIGIT-1:0]),
    .y     (b_sh[DIGIT-1:0]),
    .ci    (carry),
    .s     (slice_s),
    .co    (slice_co),
    .c_msb (slice_c_msb)
  );

  // New digit enters at the top while the partial result moves toward the LSB.
  always_comb begin
    res_next = (res_sh >> DIGIT) | (WIDTH'(slice_s) << (WIDTH - DIGIT));
  end

  // Control FSM and datapath registers; all outputs are registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_sh        <= '0;
      b_sh        <= '0;
      res_sh      <= '0;
      carry       <= 1'b0;
      cnt         <= '0;
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh       <= a;
            b_sh       <= sub ? ~b : b;
            carry      <= sub ? 1'b1 : cin;
            cnt        <= '0;
            state      <= RUN;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          res_sh <= res_next;
          carry  <= slice_co;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            cout_r      <= slice_co;
            ovf_r       <= slice_c_msb ^ slice_co;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign sum       = res_sh;
  assign cout      = cout_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder at DIGIT 1, 4 and 8
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       sub;
  logic       out_ready;

  logic       in_ready_w  [3];
  logic       out_valid_w [3];
  logic       cout_w      [3];
  logic       ovf_w       [3];
  logic       busy_w      [3];
  logic [7:0] sum_w       [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready_w[0]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_w[0]),
    .out_ready(out_ready), .sum(sum_w[0]), .cout(cout_w[0]), .ovf(ovf_w[0]),
    .busy(busy_w[0])
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready_w[1]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_w[1]),
    .out_ready(out_ready), .sum(sum_w[1]), .cout(cout_w[1]), .ovf(ovf_w[1]),
    .busy(busy_w[1])
  );

  serial_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready_w[2]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_w[2]),
    .out_ready(out_ready), .sum(sum_w[2]), .cout(cout_w[2]), .ovf(ovf_w[2]),
    .busy(busy_w[2])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one operation on instance idx, check latency and result, optionally stall the
  // output for hold cycles while scribbling on the inputs, then complete the handshake.
  task automatic run_op(input int idx, input logic [7:0] av, input logic [7:0] bv,
                        input logic ci, input logic sb, input logic [7:0] es,
                        input logic ec, input logic eo, input int lat, input int hold);
    int n;
    @(negedge clk);
    a = av; b = bv; cin = ci; sub = sb; in_valid[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[idx] = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    check_eq("in_ready_run", in_ready_w[idx], 0);
    check_eq("busy_run", busy_w[idx], 1);
    n = 0;
    while (!out_valid_w[idx] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("latency", n, lat);
    check_eq("sum", sum_w[idx], es);
    check_eq("cout", cout_w[idx], ec);
    check_eq("ovf", ovf_w[idx], eo);
    for (int i = 0; i < hold; i++) begin
      in_valid[idx] = i[0];
      a = 8'($urandom); b = 8'($urandom);
      @(negedge clk);
      check_eq("hold_sum", sum_w[idx], es);
      check_eq("hold_cout", cout_w[idx], ec);
      check_eq("hold_ovf", ovf_w[idx], eo);
      check_eq("hold_valid", out_valid_w[idx], 1);
      check_eq("hold_in_ready", in_ready_w[idx], 0);
      check_eq("hold_busy", busy_w[idx], 1);
    end
    in_valid[idx] = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("post_valid", out_valid_w[idx], 0);
    check_eq("post_in_ready", in_ready_w[idx], 1);
    check_eq("post_busy", busy_w[idx], 0);
    check_eq("post_sum_hold", sum_w[idx], es);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = '0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", in_ready_w[0], 1);
    check_eq("rst_out_valid", out_valid_w[0], 0);
    check_eq("rst_busy", busy_w[0], 0);
    check_eq("rst_sum", sum_w[0], 0);
    check_eq("rst_cout", cout_w[0], 0);
    check_eq("rst_ovf", ovf_w[0], 0);
    check_eq("rst_in_ready_d4", in_ready_w[1], 1);
    check_eq("rst_in_ready_d8", in_ready_w[2], 1);
    rst_n = 1'b1;

    run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8, 0);
    run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 8, 0);
    run_op(0, 8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0, 8, 0);
    run_op(0, 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 8, 0);
    run_op(0, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 8, 0);
    run_op(0, 8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0, 8, 5);

    // Reset asserted so that edge k+3 of an operation samples it.
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; cin = 1'b1; sub = 1'b0; in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("mid_rst_in_ready", in_ready_w[0], 1);
    check_eq("mid_rst_out_valid", out_valid_w[0], 0);
    check_eq("mid_rst_sum", sum_w[0], 0);
    check_eq("mid_rst_busy", busy_w[0], 0);
    repeat (10) begin
      @(negedge clk);
      check_eq("mid_rst_no_valid", out_valid_w[0], 0);
    end
    run_op(0, 8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0, 8, 0);

    run_op(1, 8'hA5, 8'h5B, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2, 0);
    run_op(1, 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 2, 0);
    run_op(2, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1, 0);
    run_op(2, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Multi-cycle, parametrised two-operand adder/subtractor. It processes DIGIT bits per clock, from the LSB up, and uses a ripple carry register between digits.
- Successor to the single-bit combinational full adder. Generalised to WIDTH bits, selectable add/subtract, signed-overflow flag, and a valid/ready handshake on both sides.
- Sits between operand producers and result consumers in datapath blocks where area matters more than latency.

Parameters:
- WIDTH, 8, operand/result width in bits; must be an integer multiple of DIGIT.
- DIGIT, 1, bits added per clock; 1 gives a pure bit-serial adder, WIDTH gives a single-cycle add.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: a+b+cin; 1: a-b, computed as a+~b+1.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB; for sub=1, cout=0 means a borrow occurred.
- ovf  output  1  two's-complement overflow = carry into MSB XOR carry out of MSB.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst_n is synchronous and active-low.
  - Sampled low at a rising edge, reset forces IDLE and clears all registers: in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0.
- Constants: N = WIDTH/DIGIT digit steps. A 3-state FSM runs IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, capture a into shift register A, and capture (sub ? ~b : b) into shift register B.
  - Set the carry register to (sub ? 1 : cin), clear the digit counter, then go to RUN.
  - When in_valid=0, a, b, cin and sub are don't-care.
- RUN:
  - On each edge, the low DIGIT bits of A, B and the carry feed adder_slice.
  - Slice sum enters the top DIGIT bits of the result shift register, which shifts right by DIGIT. A and B shift right by DIGIT. The carry register takes the slice carry-out.
  - The counter increments; on the edge where counter = N-1, latch cout and ovf from the final slice and go to DONE.
  - in_ready=0 throughout RUN.
- DONE:
  - out_valid=1; sum, cout and ovf are stable and match the captured operands.
  - On an edge with out_ready=1, go to IDLE and drop out_valid.
  - in_valid is ignored in DONE: there is no same-cycle re-accept.
- Latency: if operands are accepted at edge k, out_valid is first high after edge k+N (8 edges for defaults, 1 edge when DIGIT=WIDTH).
  - Throughput: at most one operation per N+2 cycles when out_ready is held high.
- After the output handshake, sum, cout and ovf hold their last value until the next accept. out_valid is their only qualifier.
- Reset mid-operation, in RUN or DONE: the result is discarded and the block is in IDLE on the next cycle. No out_valid pulse is produced.
- Operand values presented with in_valid=0 or in_ready=0 never affect state.
- out_ready held high in IDLE or RUN has no effect.

Decomposition:
- Package serial_adder_pkg holds:
  - the state encoding typedef (IDLE, RUN, DONE);
  - a function computing the counter width, clog2(WIDTH/DIGIT) with a minimum of 1.
- One sub-module, adder_slice #(DIGIT): combinational ripple of DIGIT full-adder bits.
  - Inputs: x[DIGIT], y[DIGIT], ci.
  - Outputs: s[DIGIT], co, and c_msb (carry into the slice's top bit, used for ovf).
- Elaboration-time check: WIDTH % DIGIT == 0, otherwise a fatal error.

Test Plan:
- WIDTH=8, DIGIT=1: a=0xFF, b=0x01, cin=0, sub=0, accepted at edge k -> out_valid first high after edge k+8; sum=0x00, cout=1, ovf=0.
- a=0x7F, b=0x01, cin=0, sub=0 -> sum=0x80, cout=0, ovf=1. Then a=0x12, b=0x34, cin=1 -> sum=0x47, cout=0, ovf=0.
- Subtract: a=0x05, b=0x07, sub=1, cin=1 (must be ignored) -> sum=0xFE, cout=0 (borrow), ovf=0. Then a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises, toggling in_valid, a and b -> sum, cout and ovf stable; in_ready=0; busy=1. Release out_ready -> IDLE the next cycle, in_ready=1.
- Reset mid-run: rst_n=0 at edge k+3 of an op -> next cycle in_ready=1, out_valid=0, sum=0, busy=0. Issue a=0x12, b=0x34, cin=1 -> sum=0x47 after 8 edges.
- WIDTH=8, DIGIT=4 instance: a=0xA5, b=0x5B, cin=0, sub=0 -> out_valid after edge k+2; sum=0x00, cout=1, ovf=0.
- WIDTH=8, DIGIT=8 instance: a=0x7F, b=0x01, cin=0, sub=0 -> out_valid after edge k+1; sum=0x80, cout=0, ovf=1.
